// File: rtl/sdram_arbiter.sv
// Arbitrates one SDRAM controller between a flash-emulator (SPI) port, a host port
// and periodic refresh. SPI has top priority; decisions are made only in IDLE.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 750,
  parameter int MAX_PENDING      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_enable,
  input  logic        spi_write_enable,
  input  logic [31:0] spi_addr,
  input  logic [15:0] spi_write_data,
  input  logic [1:0]  spi_write_mask,
  input  logic        spi_critical,
  input  logic        spi_refresh_inhibit,
  output logic        spi_data_valid,
  input  logic        host_enable,
  input  logic        host_write_enable,
  input  logic [31:0] host_addr,
  input  logic [15:0] host_write_data,
  input  logic [1:0]  host_write_mask,
  output logic        host_data_valid,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic        mem_refresh,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_write_data,
  output logic [1:0]  mem_write_mask,
  input  logic [15:0] mem_read_data,
  input  logic        mem_data_valid,
  output logic [15:0] read_data,
  output logic        refresh_overrun,
  output logic [1:0]  refresh_pending
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SPI     = 2'd1;
  localparam logic [1:0] ST_HOST    = 2'd2;
  localparam logic [1:0] ST_REFRESH = 2'd3;

  localparam int            TW         = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [1:0]    PEND_MAX   = 2'(MAX_PENDING);

  logic [1:0]    state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [1:0]    pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          men_q,     men_d;
  logic          mwe_q,     mwe_d;
  logic          mref_q,    mref_d;
  logic [31:0]   maddr_q,   maddr_d;
  logic [15:0]   mwd_q,     mwd_d;
  logic [1:0]    mwm_q,     mwm_d;
  logic          wrap;
  logic          refresh_done;

  always_comb begin
    state_d   = state_q;
    men_d     = men_q;
    mwe_d     = mwe_q;
    mref_d    = mref_q;
    maddr_d   = maddr_q;
    mwd_d     = mwd_q;
    mwm_d     = mwm_q;
    overrun_d = overrun_q;
    pending_d = pending_q;

    wrap         = (timer_q == TIMER_LAST);
    timer_d      = wrap ? '0 : timer_q + TIMER_ONE;
    refresh_done = (state_q == ST_REFRESH) && mem_data_valid;

    case (state_q)
      ST_IDLE: begin
        if (spi_enable) begin
          state_d = ST_SPI;
          men_d   = 1'b1;
          mwe_d   = spi_write_enable;
          maddr_d = spi_addr;
          mwd_d   = spi_write_data;
          mwm_d   = spi_write_mask;
        end else if (pending_q != 2'd0 && !spi_refresh_inhibit && !spi_critical) begin
          state_d = ST_REFRESH;
          mref_d  = 1'b1;
        end else if (host_enable && !spi_critical) begin
          state_d = ST_HOST;
          men_d   = 1'b1;
          mwe_d   = host_write_enable;
          maddr_d = host_addr;
          mwd_d   = host_write_data;
          mwm_d   = host_write_mask;
        end
      end
      ST_SPI, ST_HOST, ST_REFRESH: begin
        if (mem_data_valid) begin
          state_d = ST_IDLE;
          men_d   = 1'b0;
          mwe_d   = 1'b0;
          mref_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A wrap landing on a refresh completion cancels out: token in, token out.
    case ({wrap, refresh_done})
      2'b10:   if (pending_q != PEND_MAX) pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
    if (wrap && pending_q == PEND_MAX) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
      men_q     <= 1'b0;
      mwe_q     <= 1'b0;
      mref_q    <= 1'b0;
      maddr_q   <= '0;
      mwd_q     <= '0;
      mwm_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      men_q     <= men_d;
      mwe_q     <= mwe_d;
      mref_q    <= mref_d;
      maddr_q   <= maddr_d;
      mwd_q     <= mwd_d;
      mwm_q     <= mwm_d;
    end
  end

  assign spi_data_valid   = mem_data_valid && (state_q == ST_SPI);
  assign host_data_valid  = mem_data_valid && (state_q == ST_HOST);
  assign mem_enable       = men_q;
  assign mem_write_enable = mwe_q;
  assign mem_refresh      = mref_q;
  assign mem_addr         = maddr_q;
  assign mem_write_data   = mwd_q;
  assign mem_write_mask   = mwm_q;
  assign read_data        = mem_read_data;
  assign refresh_overrun  = overrun_q;
  assign refresh_pending  = pending_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 750, clk cycles between refresh tokens.
REQ-002 Parameter MAX_PENDING, default 3, maximum refresh tokens held (2-bit counter).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 spi_enable, spi_write_enable  in  1 each  flash-emulator request; held until spi_data_valid.
REQ-006 spi_addr  in  32; spi_write_data  in  16; spi_write_mask  in  2.
REQ-007 spi_critical  in  1  flash emulator owns the bus; host grants forbidden.
REQ-008 spi_refresh_inhibit  in  1  refresh must not start.
REQ-009 spi_data_valid  out  1; host_data_valid  out  1  completion strobes.
REQ-010 host_enable, host_write_enable  in  1 each; host_addr  in  32; host_write_data  in  16; host_write_mask  in  2.
REQ-011 mem_enable, mem_write_enable, mem_refresh  out  1 each; mem_addr  out  32; mem_write_data  out  16; mem_write_mask  out  2.
REQ-012 mem_read_data  in  16; mem_data_valid  in  1  completion from the SDRAM controller.
REQ-013 read_data  out  16  mem_read_data passed through to both ports.
REQ-014 refresh_overrun  out  1  sticky error; refresh_pending  out  2.

Function
REQ-015 States: IDLE, SPI, HOST, REFRESH; IDLE is the only state that makes grant decisions.
REQ-016 IDLE priority, evaluated each edge: spi_enable -> SPI; else refresh_pending!=0 and !spi_refresh_inhibit and !spi_critical -> REFRESH; else host_enable and !spi_critical -> HOST; else stay.
REQ-017 Grant latency: request high before edge N in IDLE -> mem_enable (or mem_refresh) high after edge N.
REQ-018 mem_* outputs are registered at grant from the winning port and held constant for the whole transaction.
REQ-019 In SPI/HOST, mem_enable stays high until mem_data_valid, even if the requester drops its enable.
REQ-020 spi_data_valid = mem_data_valid && state==SPI, combinational; host_data_valid is the same for HOST.
REQ-021 On the mem_data_valid edge: deassert mem_enable, mem_write_enable and mem_refresh; go to IDLE. At least one IDLE cycle separates transactions.
REQ-022 REFRESH: mem_refresh stays high until mem_data_valid; on completion refresh_pending decrements by 1.
REQ-023 A free-running timer counts 0..REFRESH_INTERVAL-1 and wraps. On wrap, refresh_pending increments, saturating at MAX_PENDING.
REQ-024 A wrap while refresh_pending==MAX_PENDING sets refresh_overrun; it clears only on reset.
REQ-025 Wrap and refresh completion on the same edge: refresh_pending is unchanged.
REQ-026 spi_enable rising during HOST or REFRESH is not preempted; SPI is granted on the first IDLE edge.
REQ-027 host_enable while spi_critical is high waits indefinitely; no error is flagged.
REQ-028 mem_data_valid in IDLE is ignored; no strobe is produced.

Reset
REQ-029 On reset: state=IDLE, timer=0, refresh_pending=0, refresh_overrun=0, and all mem_* outputs 0.
REQ-030 Reset during any transaction aborts it with no data_valid strobe; the first grant comes no earlier than the first edge after reset falls.

Verification
REQ-031 SPI read of addr 0x000123, mem_data_valid 4 cycles after mem_enable with data 0xBEEF -> mem_enable high 1 cycle after request; spi_data_valid 1 cycle with read_data 0xBEEF; mem_enable low next cycle.
REQ-032 spi_enable and host_enable raised the same cycle -> SPI granted first; HOST granted after one IDLE cycle following SPI completion.
REQ-033 spi_critical held high for 3000 cycles with host_enable high -> no HOST or REFRESH grant. With REFRESH_INTERVAL=750, refresh_pending saturates at 3 and refresh_overrun sets on the 4th wrap.
REQ-034 refresh_pending=1, spi_refresh_inhibit high and no SPI request -> no mem_refresh. Drop the inhibit -> mem_refresh high next edge; pending returns to 0 on mem_data_valid.
REQ-035 Host write with mask 2'b01 and data 0x00AA, host_enable dropped mid-transaction -> mem_* held until mem_data_valid; host_data_valid pulses once.
REQ-036 Reset asserted mid-SPI transaction -> mem_enable low asynchronously; no spi_data_valid; refresh_pending=0 after release.
